vlan_cfg_commit_ctrl: RTL and testbench

- Owns the per-ID VLAN configuration consumed by the VLAN parser: CAM entries, CAM must-match bits, and per-ID ACL expected field and match flags.
- Software writes go into a shadow bank. A commit request copies shadow to active only at a packet boundary, observed from the parser's input stream handshake.
- The parser never sees a configuration change mid-packet.
- Sits between the NMU register interface and vlan_parser; ACL values are muxed by the parser's vlan_sel_id.

---
 rtl/vlan_cfg_commit_ctrl_pkg.sv | 51 +++++
 rtl/vlan_cfg_commit_ctrl_if.sv | 42 ++++
 rtl/vlan_cfg_commit_ctrl_boundary_mon.sv | 41 ++++
 rtl/vlan_cfg_commit_ctrl.sv | 159 +++++++++++++++
 tb/tb_vlan_cfg_commit_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vlan_cfg_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vlan_cfg_pkg
// Shared definitions for the VLAN configuration commit controller:
//   - cfg_wr_sel encodings for the shadow write port
//   - commit FSM state enum
//   - per-ID configuration entry struct
//   - helper that merges one register write into an entry
// ---------------------------------------------------------------------------
package vlan_cfg_pkg;

  typedef logic [1:0] cfg_sel_t;

  localparam cfg_sel_t CFG_SEL_CAM     = 2'd0;
  localparam cfg_sel_t CFG_SEL_MUST    = 2'd1;
  localparam cfg_sel_t CFG_SEL_ACL_EXP = 2'd2;
  localparam cfg_sel_t CFG_SEL_ACL_FLG = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } vlan_cfg_state_e;

  typedef struct packed {
    logic [15:0] field;
    logic        must_match;
    logic [15:0] acl_exp;
    logic        match_tag;
    logic        match_pri;
  } vlan_cfg_entry_t;

  // Only the field addressed by sel changes; everything else is kept.
  function automatic vlan_cfg_entry_t vlan_cfg_apply_wr(
    input vlan_cfg_entry_t entry,
    input cfg_sel_t        sel,
    input logic [15:0]     data
  );
    vlan_cfg_entry_t upd;
    upd = entry;
    case (sel)
      CFG_SEL_CAM:     upd.field      = data;
      CFG_SEL_MUST:    upd.must_match = data[0];
      CFG_SEL_ACL_EXP: upd.acl_exp    = data;
      default: begin
        upd.match_tag = data[0];
        upd.match_pri = data[1];
      end
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/vlan_cfg_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// vlan_cfg_if
// Register-side bus of the VLAN configuration commit controller.
//   master : software / NMU side (drives writes and commit requests)
//   slave  : vlan_cfg_commit_ctrl
// Signals:
//   cfg_wr_valid/ready      shadow write handshake
//   cfg_wr_addr/sel/data    entry index, field select, write data
//   cfg_commit_req          level-sampled commit request
//   cfg_commit_done         one-cycle pulse when the active bank is updated
//   cfg_busy                commit pending
//   commit_count            completed commits (wrapping)
// ---------------------------------------------------------------------------
interface vlan_cfg_if
  import vlan_cfg_pkg::*;
#(
  parameter int AXIS_ID_WIDTH    = 4,
  parameter int COMMIT_CNT_WIDTH = 16
);
  localparam int EFF_ID_WIDTH = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH;

  logic                        cfg_wr_valid;
  logic                        cfg_wr_ready;
  logic [EFF_ID_WIDTH-1:0]     cfg_wr_addr;
  cfg_sel_t                    cfg_wr_sel;
  logic [15:0]                 cfg_wr_data;
  logic                        cfg_commit_req;
  logic                        cfg_commit_done;
  logic                        cfg_busy;
  logic [COMMIT_CNT_WIDTH-1:0] commit_count;

  modport master (
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_sel, cfg_wr_data, cfg_commit_req,
    input  cfg_wr_ready, cfg_commit_done, cfg_busy, commit_count
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_sel, cfg_wr_data, cfg_commit_req,
    output cfg_wr_ready, cfg_commit_done, cfg_busy, commit_count
  );

endinterface

// File: rtl/vlan_cfg_commit_ctrl_boundary_mon.sv
// ---------------------------------------------------------------------------
// vlan_pkt_boundary_mon
// Watches the parser input stream handshake and reports packet boundaries.
// Ports:
//   aclk, aresetn                 clock, async active-low reset
//   mon_tvalid/tready/tlast       observed stream handshake
//   in_packet                     a packet has started and not yet ended
//   commit_window                 config may change at the end of this cycle
// ---------------------------------------------------------------------------
module vlan_pkt_boundary_mon (
  input  logic aclk,
  input  logic aresetn,
  input  logic mon_tvalid,
  input  logic mon_tready,
  input  logic mon_tlast,
  output logic in_packet,
  output logic commit_window
);

  logic beat;
  logic last;

  assign beat = mon_tvalid & mon_tready;
  assign last = beat & mon_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_packet <= 1'b0;
    end else if (last) begin
      in_packet <= 1'b0;
    end else if (beat) begin
      in_packet <= 1'b1;
    end
  end

  // Idle between packets with no beat this cycle, or the final beat of a
  // packet: either way the next beat to be seen starts a fresh packet.
  // A beat outside a packet is a first beat and must see the old bank.
  assign commit_window = (~in_packet & ~beat) | last;

endmodule

// File: rtl/vlan_cfg_commit_ctrl.sv
// ---------------------------------------------------------------------------
// vlan_cfg_commit_ctrl
// Double-buffered per-ID VLAN configuration for vlan_parser. Software writes
// land in a shadow bank; a commit copies the whole shadow bank into the
// active bank only at a packet boundary of the parser input stream, so the
// parser never sees a configuration change mid-packet.
//
// Optional feature: define VLAN_CFG_HOLD_EN to drive stream_hold while a
// commit is pending between packets (upstream ANDs it into tready). Without
// it stream_hold is tied 0 and the commit waits for a natural boundary.
//
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   cfg                      register bus (vlan_cfg_if.slave)
//   mon_tvalid/tready/tlast  parser input stream handshake (observe only)
//   stream_hold              stall request towards upstream
//   vlan_sel_id              ACL select from the parser
//   vlan_field_expected      active ACL expected field for vlan_sel_id
//   vlan_match_tag/pri       active ACL flags for vlan_sel_id
//   vlan_fields              active CAM entries, one per ID
//   vlan_cam_must_match      active must-match bits, one per ID
// ---------------------------------------------------------------------------
module vlan_cfg_commit_ctrl
  import vlan_cfg_pkg::*;
#(
  parameter  int AXIS_ID_WIDTH    = 4,
  parameter  int COMMIT_CNT_WIDTH = 16,
  localparam int NUM_AXIS_ID      = 2 ** AXIS_ID_WIDTH,
  localparam int EFF_ID_WIDTH     = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  vlan_cfg_if.slave               cfg,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic                    stream_hold,
  input  logic [EFF_ID_WIDTH-1:0] vlan_sel_id,
  output logic [15:0]             vlan_field_expected,
  output logic                    vlan_match_tag,
  output logic                    vlan_match_pri,
  output logic [15:0]             vlan_fields [NUM_AXIS_ID],
  output logic                    vlan_cam_must_match [NUM_AXIS_ID]
);

  vlan_cfg_state_e             state_q;
  vlan_cfg_state_e             state_d;
  vlan_cfg_entry_t             shadow [NUM_AXIS_ID];
  vlan_cfg_entry_t             active [NUM_AXIS_ID];
  logic [COMMIT_CNT_WIDTH-1:0] commit_count_q;
  logic                        commit_done_q;
  logic                        in_packet;
  logic                        commit_window;
  logic                        wr_ready;
  logic                        busy;
  logic                        commit_fire;
  logic                        wr_fire;

  vlan_pkt_boundary_mon u_boundary_mon (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .in_packet     (in_packet),
    .commit_window (commit_window)
  );

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfg.cfg_commit_req) state_d = ST_PENDING;
      ST_PENDING: if (commit_window)      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_ready    = (state_q == ST_IDLE);
    busy        = (state_q == ST_PENDING);
    commit_fire = (state_q == ST_PENDING) & commit_window;
  end

  // Writes are only accepted in IDLE, so a write and a copy never coincide
  // and the bank being copied is stable for the whole PENDING period.
  assign wr_fire = cfg.cfg_wr_valid & wr_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) shadow[i] <= '0;
    end else if (wr_fire) begin
      shadow[cfg.cfg_wr_addr] <= vlan_cfg_apply_wr(shadow[cfg.cfg_wr_addr],
                                                   cfg.cfg_wr_sel,
                                                   cfg.cfg_wr_data);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) active[i] <= '0;
    end else if (commit_fire) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) active[i] <= shadow[i];
    end
  end

  // The done pulse is registered so it coincides with the first cycle in
  // which the parser sees the new bank and the incremented count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      commit_count_q <= '0;
      commit_done_q  <= 1'b0;
    end else begin
      commit_done_q <= commit_fire;
      if (commit_fire) begin
        commit_count_q <= commit_count_q + COMMIT_CNT_WIDTH'(1);
      end
    end
  end

  assign cfg.cfg_wr_ready    = wr_ready;
  assign cfg.cfg_busy        = busy;
  assign cfg.cfg_commit_done = commit_done_q;
  assign cfg.commit_count    = commit_count_q;

`ifdef VLAN_CFG_HOLD_EN
  // Stalling only between packets means the window opens on the very next
  // cycle (no beat, not in a packet), bounding commit latency.
  assign stream_hold = busy & ~in_packet;
`else
  // in_packet only feeds the hold path; the window already accounts for it.
  logic unused_in_packet;
  assign unused_in_packet = in_packet;
  assign stream_hold      = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_AXIS_ID; i++) begin
      vlan_fields[i]         = active[i].field;
      vlan_cam_must_match[i] = active[i].must_match;
    end
  end

  // The parser consumes ACL config combinationally in the same cycle.
  assign vlan_field_expected = active[vlan_sel_id].acl_exp;
  assign vlan_match_tag      = active[vlan_sel_id].match_tag;
  assign vlan_match_pri      = active[vlan_sel_id].match_pri;

endmodule

// File: tb/tb_vlan_cfg_commit_ctrl.sv
module tb_vlan_cfg_commit_ctrl;
  import vlan_cfg_pkg::*;

  localparam int IDW = 4;
  localparam int NID = 16;
  localparam int CW  = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  vlan_cfg_if #(.AXIS_ID_WIDTH(IDW), .COMMIT_CNT_WIDTH(CW)) cfg_bus ();

  logic           tvalid  = 1'b0;
  logic           rdy_raw = 1'b1;
  logic           tlast   = 1'b0;
  logic           mon_tready;
  logic           stream_hold;
  logic [IDW-1:0] sel_id  = '0;
  logic [15:0]    fexp;
  logic           mtag;
  logic           mpri;
  logic [15:0]    fields [NID];
  logic           must   [NID];

  // Upstream gates its ready with the hold request.
  assign mon_tready = rdy_raw & ~stream_hold;

  vlan_cfg_commit_ctrl #(.AXIS_ID_WIDTH(IDW), .COMMIT_CNT_WIDTH(CW)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .cfg                 (cfg_bus),
    .mon_tvalid          (tvalid),
    .mon_tready          (mon_tready),
    .mon_tlast           (tlast),
    .stream_hold         (stream_hold),
    .vlan_sel_id         (sel_id),
    .vlan_field_expected (fexp),
    .vlan_match_tag      (mtag),
    .vlan_match_pri      (mpri),
    .vlan_fields         (fields),
    .vlan_cam_must_match (must)
  );

  // Reference model: two banks, a pending flag, a packet flag.
  typedef struct {
    logic [15:0] f;
    bit          m;
    logic [15:0] e;
    bit          t;
    bit          p;
  } ment_t;

  ment_t       sh [NID];
  ment_t       ac [NID];
  bit          m_pend;
  bit          m_inpkt;
  bit          m_done;
  logic [15:0] m_cnt;
  int          passed = 0;
  int          total  = 0;

  function automatic bit m_hold();
`ifdef VLAN_CFG_HOLD_EN
    return m_pend && !m_inpkt;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NID; i++) begin
      sh[i] = '{16'h0, 1'b0, 16'h0, 1'b0, 1'b0};
      ac[i] = '{16'h0, 1'b0, 16'h0, 1'b0, 1'b0};
    end
    m_pend = 0; m_inpkt = 0; m_done = 0; m_cnt = '0;
  endtask

  task automatic idle_inputs();
    tvalid = 0; tlast = 0; rdy_raw = 1;
    cfg_bus.cfg_wr_valid = 0; cfg_bus.cfg_commit_req = 0;
    cfg_bus.cfg_wr_addr = '0; cfg_bus.cfg_wr_sel = CFG_SEL_CAM; cfg_bus.cfg_wr_data = '0;
  endtask

  // Advance one clock: capture inputs, apply the spec rules to the model.
  task automatic step();
    bit beat, last, win, wacc, creq;
    logic [IDW-1:0] a;
    logic [1:0]     s;
    logic [15:0]    d;
    beat = tvalid && rdy_raw && !m_hold();
    last = beat && tlast;
    win  = (!m_inpkt && !beat) || last;
    wacc = cfg_bus.cfg_wr_valid && !m_pend;
    creq = cfg_bus.cfg_commit_req;
    a = cfg_bus.cfg_wr_addr; s = cfg_bus.cfg_wr_sel; d = cfg_bus.cfg_wr_data;
    @(posedge aclk);
    #1;
    m_done = m_pend && win;
    if (m_pend && win) begin
      for (int i = 0; i < NID; i++) ac[i] = sh[i];
      m_cnt  = m_cnt + 16'd1;
      m_pend = 0;
    end else if (!m_pend && creq) begin
      m_pend = 1;
    end
    if (wacc) begin
      case (s)
        2'd0: sh[a].f = d;
        2'd1: sh[a].m = d[0];
        2'd2: sh[a].e = d;
        default: begin sh[a].t = d[0]; sh[a].p = d[1]; end
      endcase
    end
    if (last) m_inpkt = 0;
    else if (beat) m_inpkt = 1;
  endtask

  task automatic write_cfg(input int addr, input logic [1:0] sel, input logic [15:0] data);
    cfg_bus.cfg_wr_valid = 1; cfg_bus.cfg_wr_addr = IDW'(addr);
    cfg_bus.cfg_wr_sel = sel; cfg_bus.cfg_wr_data = data;
    step();
    cfg_bus.cfg_wr_valid = 0;
  endtask

  task automatic test_reset();
    bit zero;
    idle_inputs();
    model_reset();
    aresetn = 0;
    repeat (3) @(posedge aclk);
    #1;
    zero = 1;
    for (int i = 0; i < NID; i++) if (fields[i] !== 16'h0 || must[i] !== 1'b0) zero = 0;
    total++; if (zero !== 1'b1) $display("FAIL reset_banks: got nonzero active entry, expected all 0"); else passed++;
    total++; if (cfg_bus.cfg_wr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cfg_bus.cfg_wr_ready); else passed++;
    total++; if (cfg_bus.cfg_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", cfg_bus.cfg_busy); else passed++;
    total++; if (cfg_bus.cfg_commit_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", cfg_bus.cfg_commit_done); else passed++;
    total++; if (cfg_bus.commit_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", cfg_bus.commit_count); else passed++;
    @(negedge aclk);
    aresetn = 1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_commit_idle();
    write_cfg(3, CFG_SEL_CAM, 16'h0A05);
    cfg_bus.cfg_commit_req = 1;
    #1;
    total++; if (cfg_bus.cfg_wr_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", cfg_bus.cfg_wr_ready); else passed++;
    step();
    cfg_bus.cfg_commit_req = 0;
    #1;
    total++; if (cfg_bus.cfg_busy !== 1'b1) $display("FAIL pend_busy: got %b expected 1", cfg_bus.cfg_busy); else passed++;
    total++; if (cfg_bus.cfg_wr_ready !== 1'b0) $display("FAIL pend_ready: got %b expected 0", cfg_bus.cfg_wr_ready); else passed++;
    total++; if (fields[3] !== 16'h0000) $display("FAIL pend_old_cam: got %h expected 0000", fields[3]); else passed++;
    step();
    total++; if (cfg_bus.cfg_commit_done !== 1'b1) $display("FAIL idle_done: got %b expected 1", cfg_bus.cfg_commit_done); else passed++;
    total++; if (fields[3] !== 16'h0A05) $display("FAIL idle_cam3: got %h expected 0a05", fields[3]); else passed++;
    total++; if (cfg_bus.commit_count !== 16'd1) $display("FAIL idle_count: got %0d expected 1", cfg_bus.commit_count); else passed++;
    total++; if (cfg_bus.cfg_busy !== 1'b0) $display("FAIL idle_busy_after: got %b expected 0", cfg_bus.cfg_busy); else passed++;
    step();
    total++; if (cfg_bus.cfg_commit_done !== 1'b0) $display("FAIL idle_done_pulse: got %b expected 0", cfg_bus.cfg_commit_done); else passed++;
  endtask

  task automatic test_mid_packet();
    write_cfg(5, CFG_SEL_CAM, 16'h5555);
    tvalid = 1; tlast = 0; rdy_raw = 1;
    step();                                   // beat 1
    cfg_bus.cfg_commit_req = 1;
    step();                                   // beat 2 with request
    cfg_bus.cfg_commit_req = 0;
    #1;
    total++; if (cfg_bus.cfg_busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", cfg_bus.cfg_busy); else passed++;
    step();                                   // beat 3
    total++; if (fields[5] !== 16'h0000 || cfg_bus.cfg_commit_done !== 1'b0)
      $display("FAIL mid_beat3: got cam=%h done=%b expected 0000/0", fields[5], cfg_bus.cfg_commit_done); else passed++;
    tlast = 1;
    #1;
    total++; if (fields[5] !== 16'h0000) $display("FAIL mid_beat4_old: got %h expected 0000", fields[5]); else passed++;
    step();                                   // beat 4 (tlast)
    total++; if (fields[5] !== 16'h5555 || cfg_bus.cfg_commit_done !== 1'b1)
      $display("FAIL mid_commit: got cam=%h done=%b expected 5555/1", fields[5], cfg_bus.cfg_commit_done); else passed++;
    total++; if (cfg_bus.commit_count !== 16'd2) $display("FAIL mid_count: got %0d expected 2", cfg_bus.commit_count); else passed++;
    tvalid = 0; tlast = 0;
    step();
    total++; if (cfg_bus.cfg_commit_done !== 1'b0) $display("FAIL mid_done_once: got %b expected 0", cfg_bus.cfg_commit_done); else passed++;
  endtask

  task automatic test_back_to_back();
    bit prev_last;
    int dones = 0;
    write_cfg(7, CFG_SEL_CAM, 16'h7001);
    tvalid = 1; rdy_raw = 1;
    for (int b = 0; b < 12; b++) begin
      tlast = (b % 3 == 2);
      cfg_bus.cfg_commit_req = (b == 0 || b == 6);
      cfg_bus.cfg_wr_valid = (b == 1 || b == 7);
      cfg_bus.cfg_wr_addr = 4'd7; cfg_bus.cfg_wr_sel = CFG_SEL_CAM; cfg_bus.cfg_wr_data = 16'hBAD0;
      #1;
      if (b == 1 || b == 7) begin
        total++; if (cfg_bus.cfg_wr_ready !== 1'b0) $display("FAIL b2b_ready_b%0d: got %b expected 0", b, cfg_bus.cfg_wr_ready); else passed++;
      end
      prev_last = tlast;
      step();
      total++; if (cfg_bus.cfg_commit_done !== m_done) $display("FAIL b2b_done_b%0d: got %b expected %b", b, cfg_bus.cfg_commit_done, m_done); else passed++;
      if (cfg_bus.cfg_commit_done === 1'b1) begin
        dones++;
        total++; if (prev_last !== 1'b1) $display("FAIL b2b_edge_b%0d: got commit after non-last beat, expected tlast edge", b); else passed++;
      end
    end
    cfg_bus.cfg_wr_valid = 0; cfg_bus.cfg_commit_req = 0; tvalid = 0; tlast = 0;
    total++; if (dones !== 2) $display("FAIL b2b_count: got %0d expected 2", dones); else passed++;
    total++; if (fields[7] !== 16'h7001) $display("FAIL b2b_cam7: got %h expected 7001", fields[7]); else passed++;
    step();
  endtask

  task automatic test_hold();
    write_cfg(9, CFG_SEL_CAM, 16'h9999);
    tvalid = 1; rdy_raw = 1;
`ifdef VLAN_CFG_HOLD_EN
    tlast = 0; step();
    tlast = 1; cfg_bus.cfg_commit_req = 1; step();
    cfg_bus.cfg_commit_req = 0; tlast = 0;
    #1;
    total++; if (stream_hold !== 1'b1 || mon_tready !== 1'b0)
      $display("FAIL hold_on: got hold=%b tready=%b expected 1/0", stream_hold, mon_tready); else passed++;
    step();
    total++; if (cfg_bus.cfg_commit_done !== 1'b1 || fields[9] !== 16'h9999)
      $display("FAIL hold_commit: got done=%b cam=%h expected 1/9999", cfg_bus.cfg_commit_done, fields[9]); else passed++;
    total++; if (stream_hold !== 1'b0 || mon_tready !== 1'b1)
      $display("FAIL hold_off: got hold=%b tready=%b expected 0/1", stream_hold, mon_tready); else passed++;
    tlast = 1; step();
`else
    tlast = 0; step();
    cfg_bus.cfg_commit_req = 1; step();
    cfg_bus.cfg_commit_req = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (stream_hold !== 1'b0 || cfg_bus.cfg_busy !== 1'b1 || fields[9] !== 16'h0000)
        $display("FAIL nohold_k%0d: got hold=%b busy=%b cam=%h expected 0/1/0000", k, stream_hold, cfg_bus.cfg_busy, fields[9]); else passed++;
      step();
    end
    tlast = 1; step();
    total++; if (cfg_bus.cfg_commit_done !== 1'b1 || fields[9] !== 16'h9999)
      $display("FAIL nohold_commit: got done=%b cam=%h expected 1/9999", cfg_bus.cfg_commit_done, fields[9]); else passed++;
`endif
    tvalid = 0; tlast = 0;
    step();
  endtask

  task automatic test_acl();
    write_cfg(2, CFG_SEL_ACL_EXP, 16'h1234);
    write_cfg(2, CFG_SEL_ACL_FLG, 16'h0001);
    cfg_bus.cfg_commit_req = 1; step();
    cfg_bus.cfg_commit_req = 0; step();
    sel_id = 4'd2;
    #1;
    total++; if (fexp !== 16'h1234 || mtag !== 1'b1 || mpri !== 1'b0)
      $display("FAIL acl_id2: got %h/%b/%b expected 1234/1/0", fexp, mtag, mpri); else passed++;
    sel_id = 4'd1;
    #1;
    total++; if (fexp !== 16'h0000 || mtag !== 1'b0 || mpri !== 1'b0)
      $display("FAIL acl_id1: got %h/%b/%b expected 0000/0/0", fexp, mtag, mpri); else passed++;
    step();
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 400; c++) begin
      tvalid  = ($urandom_range(0, 3) != 0);
      rdy_raw = ($urandom_range(0, 3) != 0);
      tlast   = ($urandom_range(0, 2) == 0);
      cfg_bus.cfg_wr_valid   = ($urandom_range(0, 2) == 0);
      cfg_bus.cfg_wr_addr    = IDW'($urandom_range(0, NID - 1));
      cfg_bus.cfg_wr_sel     = 2'($urandom_range(0, 3));
      cfg_bus.cfg_wr_data    = 16'($urandom);
      cfg_bus.cfg_commit_req = ($urandom_range(0, 5) == 0);
      sel_id = IDW'($urandom_range(0, NID - 1));
      #1;
      total++; if (cfg_bus.cfg_wr_ready !== !m_pend || cfg_bus.cfg_busy !== m_pend)
        $display("FAIL rnd_state_c%0d: got ready=%b busy=%b expected pending=%b", c, cfg_bus.cfg_wr_ready, cfg_bus.cfg_busy, m_pend); else passed++;
      total++; if (stream_hold !== m_hold())
        $display("FAIL rnd_hold_c%0d: got %b expected %b", c, stream_hold, m_hold()); else passed++;
      total++; if (cfg_bus.cfg_commit_done !== m_done || cfg_bus.commit_count !== m_cnt)
        $display("FAIL rnd_commit_c%0d: got done=%b cnt=%0d expected %b/%0d", c, cfg_bus.cfg_commit_done, cfg_bus.commit_count, m_done, m_cnt); else passed++;
      ok = 1;
      for (int i = 0; i < NID; i++) if (fields[i] !== ac[i].f || must[i] !== ac[i].m) ok = 0;
      total++; if (ok !== 1'b1) $display("FAIL rnd_bank_c%0d: got active CAM/must differing from expected bank", c); else passed++;
      total++; if (fexp !== ac[sel_id].e || mtag !== ac[sel_id].t || mpri !== ac[sel_id].p)
        $display("FAIL rnd_acl_c%0d: got %h/%b/%b expected %h/%b/%b", c, fexp, mtag, mpri, ac[sel_id].e, ac[sel_id].t, ac[sel_id].p); else passed++;
      step();
    end
    // Drain: close any open packet so a pending commit can land.
    idle_inputs();
    tvalid = 1; tlast = 1; step();
    tvalid = 0; tlast = 0; step(); step();
  endtask

  task automatic test_reset_abort();
    bit zero;
    tvalid = 1; tlast = 0; cfg_bus.cfg_commit_req = 1;
    step();
    tvalid = 0; cfg_bus.cfg_commit_req = 0;
    step();
    total++; if (cfg_bus.cfg_busy !== 1'b1) $display("FAIL abort_pending: got %b expected 1", cfg_bus.cfg_busy); else passed++;
    sel_id = 4'd2;
    #2;
    aresetn = 0;
    #1;
    zero = 1;
    for (int i = 0; i < NID; i++) if (fields[i] !== 16'h0 || must[i] !== 1'b0) zero = 0;
    total++; if (zero !== 1'b1) $display("FAIL abort_banks: got nonzero active entry, expected all 0"); else passed++;
    total++; if (fexp !== 16'h0 || mtag !== 1'b0 || cfg_bus.cfg_busy !== 1'b0 || cfg_bus.commit_count !== 16'd0 || cfg_bus.cfg_commit_done !== 1'b0)
      $display("FAIL abort_outputs: got acl=%h tag=%b busy=%b cnt=%0d done=%b expected all 0", fexp, mtag, cfg_bus.cfg_busy, cfg_bus.commit_count, cfg_bus.cfg_commit_done); else passed++;
    model_reset();
    @(negedge aclk);
    aresetn = 1;
    @(posedge aclk);
    #1;
    total++; if (cfg_bus.cfg_wr_ready !== 1'b1 || cfg_bus.cfg_busy !== 1'b0 || cfg_bus.commit_count !== 16'd0)
      $display("FAIL abort_release: got ready=%b busy=%b cnt=%0d expected 1/0/0", cfg_bus.cfg_wr_ready, cfg_bus.cfg_busy, cfg_bus.commit_count); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_commit_idle();
    test_mid_packet();
    test_back_to_back();
    test_hold();
    test_acl();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
